// File: rtl/rd_pkg.sv
// Shared definitions for the RD serial receiver: FSM encoding, frame geometry
// and the layout of the 32-bit event-buffer word.
package rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

    localparam int RD_WORD_BITS  = 12;
    localparam int RD_FRAME_BITS = RD_WORD_BITS + 1;
    localparam int RD_MEM_SIZE   = 2048;

    // MEM_DIN = {PERR1, PERR0, 2'b0, DATA1, 4'b0, DATA0}
    localparam int RD_DIN_W      = 32;
    localparam int RD_LANE0_LSB  = 0;
    localparam int RD_LANE1_LSB  = 16;
    localparam int RD_PERR0_BIT  = 30;
    localparam int RD_PERR1_BIT  = 31;

endpackage

// File: rtl/rd_serial_rx_if.sv
// Event-buffer write port driven by the RD serial receiver.
interface rd_serial_rx_if
    import rd_pkg::*;
#(
    parameter int ADDR_W = 11
);

    logic [ADDR_W-1:0]   MEM_ADDR;
    logic [RD_DIN_W-1:0] MEM_DIN;
    logic                MEM_WE;

    modport master (output MEM_ADDR, output MEM_DIN, output MEM_WE);
    modport slave  (input  MEM_ADDR, input  MEM_DIN, input  MEM_WE);

endinterface

// File: rtl/rd_lane_deser.sv
// One-lane deserialiser: shifts in WORD_BITS data bits MSB first, then checks
// the odd-parity bit and presents the finished word with its parity flag.
module rd_lane_deser
    import rd_pkg::*;
#(
    parameter int WORD_BITS = RD_WORD_BITS
) (
    input  logic                 LOCAL_CLK,
    input  logic                 RESETN,
    input  logic                 shift_en,
    input  logic                 last_bit,
    input  logic                 serial_bit,
    output logic [WORD_BITS-1:0] data_word,
    output logic                 parity_err
);

    logic [WORD_BITS-1:0] shift_reg;
    logic                 running_par;

    // The parity accumulator restarts on every frame and whenever shifting stops,
    // so an aborted transfer never leaks into the next one.
    always_ff @(posedge LOCAL_CLK or negedge RESETN) begin
        if (!RESETN) begin
            shift_reg   <= '0;
            running_par <= 1'b0;
            data_word   <= '0;
            parity_err  <= 1'b0;
        end else if (!shift_en) begin
            running_par <= 1'b0;
        end else if (last_bit) begin
            data_word   <= shift_reg;
            parity_err  <= ~(running_par ^ serial_bit);
            running_par <= 1'b0;
        end else begin
            shift_reg   <= {shift_reg[WORD_BITS-2:0], serial_bit};
            running_par <= running_par ^ serial_bit;
        end
    end

endmodule

// File: rtl/rd_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the LOCAL_CLK domain.
module rd_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic LOCAL_CLK,
    input  logic RESETN,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge LOCAL_CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_ff[STAGES-1];

endmodule

// File: rtl/rd_serial_rx.sv
// RD two-lane serial receiver: frames SERIAL_IN0/1 during ENABLE_XFR and writes
// one packed 32-bit word per frame into the event buffer, with transfer status.
module rd_serial_rx
    import rd_pkg::*;
#(
    parameter int MEM_SIZE  = RD_MEM_SIZE,
    parameter int ADDR_W    = 11,
    parameter int WORD_BITS = RD_WORD_BITS,
    parameter int PERR_W    = 16
) (
    input  logic              LOCAL_CLK,
    input  logic              RESETN,
    input  logic              ENABLE,
    input  logic              ENABLE_XFR,
    input  logic              SERIAL_IN0,
    input  logic              SERIAL_IN1,
    rd_serial_rx_if.master    mem,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W:0]   WORD_COUNT,
    output logic [PERR_W-1:0] PARITY_ERRS,
    output logic              FRAME_ERR,
    output logic              OVERRUN
);

    localparam int                FRAME_BITS = WORD_BITS + 1;
    localparam int                CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_BITS - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(MEM_SIZE);
    localparam logic [PERR_W-1:0] PERR_MAX   = '1;

    rd_state_t            state, state_next;
    logic                 en_sync, en_xfr_q, en_xfr_prev, sin0_q, sin1_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 shifting, last_bit;
    logic                 arm, frame_ok, frame_err_set;
    logic                 word_ready, accept, do_write, overrun_set;
    logic [WORD_BITS-1:0] data0, data1;
    logic                 perr0, perr1;
    logic [ADDR_W:0]      word_count;
    logic [PERR_W-1:0]    perr_count;
    logic                 frame_err_r, overrun_r, done_r, mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [RD_DIN_W-1:0]  mem_din_r, din_next;

    rd_synchronizer #(.STAGES(2)) u_enable_sync (
        .LOCAL_CLK (LOCAL_CLK),
        .RESETN    (RESETN),
        .async_in  (ENABLE),
        .sync_out  (en_sync)
    );

    always_ff @(posedge LOCAL_CLK or negedge RESETN) begin
        if (!RESETN) begin
            en_xfr_q    <= 1'b0;
            en_xfr_prev <= 1'b0;
            sin0_q      <= 1'b0;
            sin1_q      <= 1'b0;
        end else begin
            en_xfr_q    <= ENABLE_XFR;
            en_xfr_prev <= en_xfr_q;
            sin0_q      <= SERIAL_IN0;
            sin1_q      <= SERIAL_IN1;
        end
    end

    always_ff @(posedge LOCAL_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Losing the arm level wins over everything; ENABLE_XFR falling ends the
    // transfer cleanly only when it coincides with the parity sample.
    always_comb begin
        state_next    = state;
        arm           = 1'b0;
        frame_ok      = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_sync) begin
                    state_next = ST_ARMED;
                    arm        = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!en_sync) begin
                    state_next = ST_IDLE;
                end else if (en_xfr_q && !en_xfr_prev) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!en_sync) begin
                    state_next = ST_IDLE;
                end else begin
                    frame_ok = last_bit;
                    if (!en_xfr_q) begin
                        state_next    = ST_DONE;
                        frame_err_set = !last_bit;
                    end
                end
            end
            ST_DONE: begin
                if (!en_sync) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign shifting = (state == ST_SHIFT);
    assign last_bit = (bit_cnt == LAST_BIT);

    always_ff @(posedge LOCAL_CLK or negedge RESETN) begin
        if (!RESETN) begin
            bit_cnt <= '0;
        end else if (!shifting || last_bit) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    rd_lane_deser #(.WORD_BITS(WORD_BITS)) u_lane0 (
        .LOCAL_CLK  (LOCAL_CLK),
        .RESETN     (RESETN),
        .shift_en   (shifting),
        .last_bit   (last_bit),
        .serial_bit (sin0_q),
        .data_word  (data0),
        .parity_err (perr0)
    );

    rd_lane_deser #(.WORD_BITS(WORD_BITS)) u_lane1 (
        .LOCAL_CLK  (LOCAL_CLK),
        .RESETN     (RESETN),
        .shift_en   (shifting),
        .last_bit   (last_bit),
        .serial_bit (sin1_q),
        .data_word  (data1),
        .parity_err (perr1)
    );

    // A finished frame is written one cycle after the deserialisers latch it;
    // a disarm in between cancels the write.
    assign accept      = word_ready && en_sync;
    assign do_write    = accept && (word_count != FULL_COUNT);
    assign overrun_set = accept && (word_count == FULL_COUNT);

    always_comb begin
        din_next                                = '0;
        din_next[RD_LANE0_LSB +: WORD_BITS]     = data0;
        din_next[RD_LANE1_LSB +: WORD_BITS]     = data1;
        din_next[RD_PERR0_BIT]                  = perr0;
        din_next[RD_PERR1_BIT]                  = perr1;
    end

    always_ff @(posedge LOCAL_CLK or negedge RESETN) begin
        if (!RESETN) begin
            word_ready  <= 1'b0;
            word_count  <= '0;
            perr_count  <= '0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            done_r      <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_din_r   <= '0;
        end else begin
            word_ready <= frame_ok;
            mem_we_r   <= do_write;
            done_r     <= (state == ST_DONE) && !word_ready;
            if (do_write) begin
                mem_addr_r <= word_count[ADDR_W-1:0];
                mem_din_r  <= din_next;
            end
            if (arm) begin
                word_count  <= '0;
                perr_count  <= '0;
                frame_err_r <= 1'b0;
                overrun_r   <= 1'b0;
            end else begin
                if (do_write) begin
                    word_count <= word_count + 1'b1;
                end
                if (accept && (perr0 || perr1) && (perr_count != PERR_MAX)) begin
                    perr_count <= perr_count + 1'b1;
                end
                if (frame_err_set) begin
                    frame_err_r <= 1'b1;
                end
                if (overrun_set) begin
                    overrun_r <= 1'b1;
                end
            end
        end
    end

    assign BUSY         = (state == ST_ARMED) || (state == ST_SHIFT);
    assign DONE         = done_r;
    assign WORD_COUNT   = word_count;
    assign PARITY_ERRS  = perr_count;
    assign FRAME_ERR    = frame_err_r;
    assign OVERRUN      = overrun_r;
    assign mem.MEM_WE   = mem_we_r;
    assign mem.MEM_ADDR = mem_addr_r;
    assign mem.MEM_DIN  = mem_din_r;

endmodule

// File: tb/tb_rd_serial_rx.sv
// Bench for rd_serial_rx: drives two-lane frames and compares buffer writes and
// status against a word-list reference model.
module tb_rd_serial_rx;

    localparam int MEM_SIZE = 2048;
    localparam int ADDR_W   = 11;
    localparam int PERR_W   = 16;

    logic LOCAL_CLK  = 1'b0;
    logic RESETN     = 1'b0;
    logic ENABLE     = 1'b0;
    logic ENABLE_XFR = 1'b0;
    logic SERIAL_IN0 = 1'b0;
    logic SERIAL_IN1 = 1'b0;
    logic              BUSY, DONE, FRAME_ERR, OVERRUN;
    logic [ADDR_W:0]   WORD_COUNT;
    logic [PERR_W-1:0] PARITY_ERRS;

    rd_serial_rx_if #(.ADDR_W(ADDR_W)) mem_if ();

    rd_serial_rx #(
        .MEM_SIZE (MEM_SIZE),
        .ADDR_W   (ADDR_W),
        .WORD_BITS(12),
        .PERR_W   (PERR_W)
    ) dut (
        .LOCAL_CLK  (LOCAL_CLK),
        .RESETN     (RESETN),
        .ENABLE     (ENABLE),
        .ENABLE_XFR (ENABLE_XFR),
        .SERIAL_IN0 (SERIAL_IN0),
        .SERIAL_IN1 (SERIAL_IN1),
        .mem        (mem_if),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .WORD_COUNT (WORD_COUNT),
        .PARITY_ERRS(PARITY_ERRS),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN)
    );

    always #5 LOCAL_CLK = ~LOCAL_CLK;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int first_we_cyc = -1;
    int parity_cyc   = -1;

    logic [11:0] tx0[$];
    logic [11:0] tx1[$];
    bit          flip0[$];
    bit          flip1[$];
    int          wr_addr_q[$];
    logic [31:0] wr_din_q[$];

    always @(posedge LOCAL_CLK) cyc++;

    always @(negedge LOCAL_CLK) begin
        if (mem_if.MEM_WE === 1'b1) begin
            if (wr_addr_q.size() == 0) first_we_cyc = cyc;
            wr_addr_q.push_back(int'(mem_if.MEM_ADDR));
            wr_din_q.push_back(mem_if.MEM_DIN);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference word: lane data in the low halves, a parity flag wherever the bench corrupted a parity bit.
    function automatic logic [31:0] expected_word(input int i);
        logic [31:0] w;
        w = {20'h0, tx0[i]} | ({20'h0, tx1[i]} << 16);
        if (flip0[i]) w = w | 32'h4000_0000;
        if (flip1[i]) w = w | 32'h8000_0000;
        return w;
    endfunction

    function automatic logic [31:0] din_at(input int a);
        logic [31:0] r;
        r = 'x;
        foreach (wr_addr_q[k]) if (wr_addr_q[k] == a) r = wr_din_q[k];
        return r;
    endfunction

    task automatic build_words(input int n, input bit counter);
        tx0.delete(); tx1.delete(); flip0.delete(); flip1.delete();
        for (int i = 0; i < n; i++) begin
            if (counter) begin
                tx0.push_back(12'(i));
                tx1.push_back(12'(0 - i));
            end else begin
                tx0.push_back(12'($urandom));
                tx1.push_back(12'($urandom));
            end
            flip0.push_back(1'b0);
            flip1.push_back(1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"}, BUSY, 0);
        checkOutput({tag, "_done"}, DONE, 0);
        checkOutput({tag, "_word_count"}, WORD_COUNT, 0);
        checkOutput({tag, "_parity_errs"}, PARITY_ERRS, 0);
        checkOutput({tag, "_frame_err"}, FRAME_ERR, 0);
        checkOutput({tag, "_overrun"}, OVERRUN, 0);
        checkOutput({tag, "_mem_we"}, mem_if.MEM_WE, 0);
        checkOutput({tag, "_mem_addr"}, mem_if.MEM_ADDR, 0);
        checkOutput({tag, "_mem_din"}, mem_if.MEM_DIN, 0);
    endtask

    task automatic arm(input string tag);
        ENABLE = 1'b1;
        repeat (4) @(negedge LOCAL_CLK);
        checkOutput({tag, "_armed_busy"}, BUSY, 1);
        checkOutput({tag, "_armed_wc"}, WORD_COUNT, 0);
    endtask

    task automatic disarm();
        ENABLE = 1'b0;
        repeat (4) @(negedge LOCAL_CLK);
    endtask

    // Frame driver: ENABLE_XFR rises one bit-time ahead of D11 of word 0 and falls with the last parity bit.
    task automatic applyStimulus(input int n_words, input int abort_word, input int abort_pos,
                                 input int drop_word, input int reset_word);
        bit          stop    = 1'b0;
        bit          dropped = 1'b0;
        int          drop_cycles = 0;
        logic [11:0] d0, d1;
        wr_addr_q.delete(); wr_din_q.delete();
        first_we_cyc = -1;
        @(negedge LOCAL_CLK);
        ENABLE_XFR = 1'b1; SERIAL_IN0 = 1'b0; SERIAL_IN1 = 1'b0;
        for (int w = 0; w < n_words && !stop; w++) begin
            d0 = tx0[w];
            d1 = tx1[w];
            for (int j = 0; j < 13 && !stop; j++) begin
                @(negedge LOCAL_CLK);
                if (dropped) begin
                    drop_cycles++;
                    if (drop_cycles == 3) checkOutput("t6_busy_after_drop", BUSY, 0);
                end
                if (w == abort_word && j == abort_pos) begin
                    ENABLE_XFR = 1'b0; SERIAL_IN0 = 1'b0; SERIAL_IN1 = 1'b0;
                    stop = 1'b1;
                end else if (w == reset_word && j == 5) begin
                    RESETN = 1'b0;
                    #1;
                    check_all_zero("t5_reset");
                    ENABLE = 1'b0; ENABLE_XFR = 1'b0; SERIAL_IN0 = 1'b0; SERIAL_IN1 = 1'b0;
                    stop = 1'b1;
                end else begin
                    if (w == drop_word && j == 5 && !dropped) begin
                        ENABLE  = 1'b0;
                        dropped = 1'b1;
                    end
                    if (j < 12) begin
                        SERIAL_IN0 = d0[11-j];
                        SERIAL_IN1 = d1[11-j];
                    end else begin
                        SERIAL_IN0 = ~(^d0) ^ flip0[w];
                        SERIAL_IN1 = ~(^d1) ^ flip1[w];
                        if (w == 0) parity_cyc = cyc;
                    end
                    ENABLE_XFR = !(w == n_words - 1 && j == 12);
                end
            end
        end
        @(negedge LOCAL_CLK);
        ENABLE_XFR = 1'b0; SERIAL_IN0 = 1'b0; SERIAL_IN1 = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (DONE !== 1'b1 && n < 40) begin
            @(negedge LOCAL_CLK);
            n++;
        end
    endtask

    task automatic check_transfer(input string tag, input int n_complete, input bit exp_fe, input bit exp_done);
        int n_wr = (n_complete > MEM_SIZE) ? MEM_SIZE : n_complete;
        int bad  = 0;
        int perr = 0;
        foreach (wr_addr_q[i]) begin
            if (i >= n_wr || wr_addr_q[i] != i || wr_din_q[i] !== expected_word(i)) bad++;
        end
        for (int i = 0; i < n_complete; i++) if (flip0[i] || flip1[i]) perr++;
        if (perr > 65535) perr = 65535;
        checkOutput({tag, "_writes"}, wr_addr_q.size(), n_wr);
        checkOutput({tag, "_data_errs"}, bad, 0);
        checkOutput({tag, "_word_count"}, WORD_COUNT, n_wr);
        checkOutput({tag, "_parity_errs"}, PARITY_ERRS, perr);
        checkOutput({tag, "_frame_err"}, FRAME_ERR, exp_fe);
        checkOutput({tag, "_overrun"}, OVERRUN, n_complete > MEM_SIZE);
        checkOutput({tag, "_done"}, DONE, exp_done);
        checkOutput({tag, "_busy"}, BUSY, 0);
    endtask

    initial begin
        int addr0_cnt;
        repeat (3) @(negedge LOCAL_CLK);
        check_all_zero("reset");
        RESETN = 1'b1;
        repeat (2) @(negedge LOCAL_CLK);

        // Full-buffer counter pattern
        build_words(MEM_SIZE, 1'b1);
        arm("t1");
        applyStimulus(MEM_SIZE, -1, -1, -1, -1);
        wait_done();
        check_transfer("t1", MEM_SIZE, 1'b0, 1'b1);
        checkOutput("t1_addr5_din", din_at(5), 32'h0FFB_0005);
        checkOutput("t1_first_we_latency", first_we_cyc - parity_cyc, 3);
        disarm();
        checkOutput("t1_idle_done", DONE, 0);
        checkOutput("t1_idle_wc_retained", WORD_COUNT, MEM_SIZE);

        // Lane-1 parity corrupted on word 3
        build_words(16, 1'b0);
        flip1[3] = 1'b1;
        arm("t2");
        applyStimulus(16, -1, -1, -1, -1);
        wait_done();
        check_transfer("t2", 16, 1'b0, 1'b1);
        checkOutput("t2_addr3_perr1", din_at(3) >> 31, 1);
        checkOutput("t2_addr3_perr0", (din_at(3) >> 30) & 32'h1, 0);
        disarm();

        // Random parity errors on both lanes
        build_words(40, 1'b0);
        for (int i = 0; i < 40; i++) begin
            flip0[i] = ($urandom_range(0, 3) == 0);
            flip1[i] = ($urandom_range(0, 3) == 0);
        end
        arm("t2b");
        applyStimulus(40, -1, -1, -1, -1);
        wait_done();
        check_transfer("t2b", 40, 1'b0, 1'b1);
        disarm();

        // ENABLE_XFR falls mid-frame in word 10, then is ignored while DONE
        build_words(20, 1'b0);
        arm("t3");
        applyStimulus(20, 10, 7, -1, -1);
        wait_done();
        check_transfer("t3", 10, 1'b1, 1'b1);
        wr_addr_q.delete(); wr_din_q.delete();
        ENABLE_XFR = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge LOCAL_CLK);
            SERIAL_IN0 = 1'($urandom); SERIAL_IN1 = 1'($urandom);
        end
        ENABLE_XFR = 1'b0;
        repeat (5) @(negedge LOCAL_CLK);
        checkOutput("t3_done_ignores_xfr_writes", wr_addr_q.size(), 0);
        checkOutput("t3_done_ignores_xfr_wc", WORD_COUNT, 10);
        disarm();

        // Two frames beyond buffer capacity
        build_words(MEM_SIZE + 2, 1'b0);
        arm("t4");
        applyStimulus(MEM_SIZE + 2, -1, -1, -1, -1);
        wait_done();
        check_transfer("t4", MEM_SIZE + 2, 1'b0, 1'b1);
        addr0_cnt = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == 0) addr0_cnt++;
        checkOutput("t4_addr0_writes", addr0_cnt, 1);
        disarm();

        // Reset during word 100, then a short clean transfer
        build_words(200, 1'b0);
        arm("t5");
        applyStimulus(200, -1, -1, -1, 100);
        repeat (3) @(negedge LOCAL_CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge LOCAL_CLK);
        build_words(4, 1'b0);
        arm("t5b");
        applyStimulus(4, -1, -1, -1, -1);
        wait_done();
        check_transfer("t5b", 4, 1'b0, 1'b1);
        disarm();

        // ENABLE dropped during word 50
        build_words(60, 1'b0);
        arm("t6");
        applyStimulus(60, -1, -1, 50, -1);
        repeat (20) @(negedge LOCAL_CLK);
        check_transfer("t6", 50, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
